// File: rtl/arbitro_multiplicador.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_multiplicador
// Brief   : Round-robin arbiter sharing one shift-add multiplier between two
//           requesters, with sign correction and a watchdog abort.
// Rev     : 1.0
// ============================================================================
module arbitro_multiplicador #(
    parameter int TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Req,
    input  logic [1:0]  Sinal,
    input  logic [15:0] OpA0,
    input  logic [15:0] OpB0,
    input  logic [15:0] OpA1,
    input  logic [15:0] OpB1,
    output logic [1:0]  Ack,
    output logic        Erro,
    output logic [31:0] Resultado,
    output logic        Ocupado,
    output logic        St,
    output logic [15:0] Multiplicando,
    output logic [15:0] Multiplicador,
    input  logic        Idle,
    input  logic        Done,
    input  logic [31:0] Produto
);

    localparam logic [7:0] c_CNT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LIVRE   = 2'd0,
        INICIA  = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    estado_t     state_q, state_d;
    logic        g_q, g_d;
    logic        neg_q, neg_d;
    logic        prio_q, prio_d;
    logic        erro_q, erro_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] res_q, res_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        w_sel;
    logic        w_signed;
    logic [15:0] w_op_a;
    logic [15:0] w_op_b;
    logic [15:0] w_mag_a;
    logic [15:0] w_mag_b;

    // Candidate winner: the sole requester, or the favoured one on a tie.
    assign w_sel    = (Req == 2'b11) ? prio_q : Req[1];
    assign w_op_a   = w_sel ? OpA1 : OpA0;
    assign w_op_b   = w_sel ? OpB1 : OpB0;
    assign w_signed = Sinal[w_sel];
    // -32768 negates to 16'h8000, which the unsigned multiplier reads as 32768.
    assign w_mag_a  = (w_signed && w_op_a[15]) ? (~w_op_a + 16'd1) : w_op_a;
    assign w_mag_b  = (w_signed && w_op_b[15]) ? (~w_op_b + 16'd1) : w_op_b;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= LIVRE;
            g_q      <= 1'b0;
            neg_q    <= 1'b0;
            prio_q   <= 1'b0;
            erro_q   <= 1'b0;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            res_q    <= 32'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            neg_q    <= neg_d;
            prio_q   <= prio_d;
            erro_q   <= erro_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        neg_d    = neg_q;
        prio_d   = prio_q;
        erro_d   = erro_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        res_d    = res_q;
        cnt_d    = cnt_q;

        case (state_q)
            LIVRE: begin
                if (Idle && (Req != 2'b00)) begin
                    g_d      = w_sel;
                    mcand_d  = w_mag_a;
                    mplier_d = w_mag_b;
                    neg_d    = w_signed & (w_op_a[15] ^ w_op_b[15]);
                    state_d  = INICIA;
                end
            end
            INICIA: begin
                cnt_d   = 8'd0;
                state_d = ESPERA;
            end
            ESPERA: begin
                // Done wins over an expiring watchdog in the same cycle.
                if (Done) begin
                    res_d   = neg_q ? (~Produto + 32'd1) : Produto;
                    erro_d  = 1'b0;
                    state_d = ENTREGA;
                end else if (cnt_q == c_CNT_MAX) begin
                    res_d   = 32'd0;
                    erro_d  = 1'b1;
                    state_d = ENTREGA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ENTREGA: begin
                prio_d  = ~g_q;
                state_d = LIVRE;
            end
            default: begin
                state_d = LIVRE;
            end
        endcase
    end

    assign St            = (state_q == INICIA);
    assign Ocupado       = (state_q != LIVRE);
    assign Ack           = (state_q == ENTREGA) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign Erro          = (state_q == ENTREGA) & erro_q;
    assign Resultado     = res_q;
    assign Multiplicando = mcand_q;
    assign Multiplicador = mplier_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_multiplicador.sv
`default_nettype none
// Bench for arbitro_multiplicador: behavioural multiplier, cycle-level reference
// model with a per-cycle compare, plus directed vectors with literal results.
module tb_arbitro_multiplicador;

    localparam int TO = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  Req = 2'b00;
    logic [1:0]  Sinal = 2'b00;
    logic [15:0] OpA0 = '0, OpB0 = '0, OpA1 = '0, OpB1 = '0;
    logic [1:0]  Ack;
    logic        Erro;
    logic [31:0] Resultado;
    logic        Ocupado;
    logic        St;
    logic [15:0] Multiplicando, Multiplicador;
    logic        Idle = 1'b1;
    logic        Done = 1'b0;
    logic [31:0] Produto = '0;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    arbitro_multiplicador #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Sinal(Sinal),
        .OpA0(OpA0), .OpB0(OpB0), .OpA1(OpA1), .OpB1(OpB1),
        .Ack(Ack), .Erro(Erro), .Resultado(Resultado), .Ocupado(Ocupado),
        .St(St), .Multiplicando(Multiplicando), .Multiplicador(Multiplicador),
        .Idle(Idle), .Done(Done), .Produto(Produto)
    );

    // Multiplier stand-in: Done arrives mul_lat cycles after the St cycle.
    int          mul_lat = 4;
    bit          mul_hang = 1'b0;
    bit          mul_kick = 1'b0;
    int          mul_cnt = 0;
    bit          mul_run = 1'b0;
    logic [31:0] mul_p = '0;

    always @(posedge Clk) begin
        if (St) begin
            mul_p   <= 32'(Multiplicando) * 32'(Multiplicador);
            mul_cnt <= mul_lat - 1;
            mul_run <= !mul_hang;
            Idle    <= 1'b0;
            Done    <= 1'b0;
        end else if (mul_kick) begin
            mul_run <= 1'b0;
            Idle    <= 1'b1;
            Done    <= 1'b0;
        end else if (Done) begin
            Done <= 1'b0;
            Idle <= 1'b1;
        end else if (mul_run) begin
            if (mul_cnt == 1) begin
                Done    <= 1'b1;
                Produto <= mul_p;
                mul_run <= 1'b0;
            end else begin
                mul_cnt <= mul_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mag(input logic [15:0] x, input logic s);
        int v;
        v = s ? int'($signed(x)) : int'(x);
        if (v < 0) v = -v;
        return v[15:0];
    endfunction

    function automatic logic [31:0] exp_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint pa, pb;
        logic [63:0] p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = 64'(pa * pb);
        return p[31:0];
    endfunction

    // Reference model: busy from grant to Ack; St one cycle after grant; Ack one
    // cycle after Done or after TO cycles of waiting, whichever comes first.
    int          cyc = 0;
    bit          m_busy = 1'b0, m_prio = 1'b0, m_g = 1'b0, m_err = 1'b0, m_after_rst = 1'b0;
    int          m_st_cyc = 0, m_ack_cyc = 0;
    logic [15:0] m_ma = '0, m_mb = '0;
    logic [31:0] m_res = '0;

    always @(negedge Clk) begin : p_model
        logic [1:0]  eack;
        logic [15:0] a, b;
        logic        s;
        int          wc;
        eack = (m_busy && cyc == m_ack_cyc) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
        chk("m_ack", 32'(Ack), 32'(eack));
        chk("m_st", 32'(St), 32'(m_busy && cyc == m_st_cyc));
        chk("m_ocupado", 32'(Ocupado), 32'(m_busy));
        if (eack != 2'b00) begin
            chk("m_resultado", Resultado, m_res);
            chk("m_erro", 32'(Erro), 32'(m_err));
        end
        if (m_busy && cyc >= m_st_cyc && cyc < m_ack_cyc) begin
            chk("m_mcand", 32'(Multiplicando), 32'(m_ma));
            chk("m_mplier", 32'(Multiplicador), 32'(m_mb));
        end
        if (m_after_rst) begin
            chk("m_rst_res", Resultado, 32'd0);
            chk("m_rst_mcand", 32'(Multiplicando), 32'd0);
            chk("m_rst_mplier", 32'(Multiplicador), 32'd0);
            chk("m_rst_erro", 32'(Erro), 32'd0);
        end

        m_after_rst = 1'b0;
        if (Rst) begin
            m_busy      = 1'b0;
            m_prio      = 1'b0;
            m_after_rst = 1'b1;
        end else if (m_busy) begin
            if (cyc == m_ack_cyc) begin
                m_busy = 1'b0;
                m_prio = !m_g;
            end
        end else if (Idle && Req != 2'b00) begin
            m_g   = (Req == 2'b11) ? m_prio : Req[1];
            a     = m_g ? OpA1 : OpA0;
            b     = m_g ? OpB1 : OpB0;
            s     = Sinal[m_g];
            m_ma  = mag(a, s);
            m_mb  = mag(b, s);
            m_err = mul_hang || (mul_lat > TO);
            wc    = m_err ? TO : mul_lat;
            m_res = m_err ? 32'd0 : exp_prod(a, b, s);
            m_st_cyc  = cyc + 1;
            m_ack_cyc = cyc + 2 + wc;
            m_busy    = 1'b1;
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_st(input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (St) break;
        end
        chk(name, 32'(St), 32'd1);
    endtask

    task automatic wait_ack(input string name, input logic [1:0] ea, input logic [31:0] er, input logic ee);
        for (int n = 0; n < 200; n++) begin
            @(negedge Clk);
            if (Ack != 2'b00) break;
        end
        chk({name, "_ack"}, 32'(Ack), 32'(ea));
        chk({name, "_res"}, Resultado, er);
        chk({name, "_erro"}, 32'(Erro), 32'(ee));
    endtask

    task automatic run_op(input string name, input logic [1:0] rq, input logic [1:0] sn,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input logic [1:0] ea, input logic [31:0] er, input logic ee);
        Sinal = sn; OpA0 = a0; OpB0 = b0; OpA1 = a1; OpB1 = b1; Req = rq;
        wait_ack(name, ea, er, ee);
        tick();
        Req = 2'b00;
    endtask

    initial begin
        int n;
        tick(2);
        @(negedge Clk);
        chk("rst_ack", 32'(Ack), 32'd0);
        chk("rst_ocupado", 32'(Ocupado), 32'd0);
        chk("rst_st", 32'(St), 32'd0);
        chk("rst_res", Resultado, 32'd0);
        tick();
        Rst = 1'b0;

        // Basic unsigned product, then Ocupado must fall right after Ack.
        Sinal = 2'b00; OpA0 = 16'd12; OpB0 = 16'd10; Req = 2'b01;
        wait_ack("u12x10", 2'b01, 32'd120, 1'b0);
        tick();
        Req = 2'b00;
        @(negedge Clk);
        chk("ocupado_after_ack", 32'(Ocupado), 32'd0);
        tick();

        // Signed negative operand on requester 1: magnitudes go to the multiplier.
        Sinal = 2'b10; OpA1 = 16'hFF38; OpB1 = 16'd3; Req = 2'b10;
        wait_st("st_neg200");
        chk("mcand_200", 32'(Multiplicando), 32'd200);
        chk("mplier_3", 32'(Multiplicador), 32'd3);
        wait_ack("s_m200x3", 2'b10, 32'hFFFFFDA8, 1'b0);
        tick();
        Req = 2'b00;

        run_op("s_min_x_min", 2'b01, 2'b01, 16'h8000, 16'h8000, 16'h0, 16'h0, 2'b01, 32'h40000000, 1'b0);
        run_op("u_ffff_sq", 2'b01, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 2'b01, 32'hFFFE0001, 1'b0);
        run_op("s_7xm3", 2'b01, 2'b01, 16'd7, 16'hFFFD, 16'h0, 16'h0, 2'b01, 32'hFFFFFFEB, 1'b0);
        run_op("s_0xm5", 2'b10, 2'b10, 16'h0, 16'h0, 16'h0, 16'hFFFB, 2'b10, 32'd0, 1'b0);

        // Both requesting continuously from reset: strict alternation.
        Rst = 1'b1;
        Sinal = 2'b10; OpA0 = 16'd5; OpB0 = 16'd7; OpA1 = 16'hFFFC; OpB1 = 16'd6; Req = 2'b11;
        tick();
        Rst = 1'b0;
        wait_ack("rr0", 2'b01, 32'd35, 1'b0);
        wait_ack("rr1", 2'b10, 32'hFFFFFFE8, 1'b0);
        wait_ack("rr2", 2'b01, 32'd35, 1'b0);
        wait_ack("rr3", 2'b10, 32'hFFFFFFE8, 1'b0);
        tick();
        Req = 2'b00;
        tick();

        // Hung multiplier: Ack exactly TO cycles after ESPERA entry, i.e. TO+1 after St.
        mul_hang = 1'b1;
        Sinal = 2'b00; OpA0 = 16'd3; OpB0 = 16'd4; Req = 2'b01;
        wait_st("st_hang");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            n++;
            if (Ack != 2'b00) break;
        end
        chk("timeout_latency", 32'(n), 32'(TO + 1));
        chk("timeout_ack", 32'(Ack), 32'd1);
        chk("timeout_res", Resultado, 32'd0);
        chk("timeout_erro", 32'(Erro), 32'd1);
        tick();
        Req = 2'b00;
        mul_hang = 1'b0;
        mul_kick = 1'b1;
        tick();
        mul_kick = 1'b0;
        tick();

        // Done on the watchdog's last cycle wins; one cycle later it is too late.
        mul_lat = TO;
        run_op("lat_eq_to", 2'b10, 2'b10, 16'h0, 16'h0, 16'hFFF6, 16'd9, 2'b10, 32'hFFFFFFA6, 1'b0);
        mul_lat = TO + 1;
        run_op("lat_gt_to", 2'b01, 2'b00, 16'd100, 16'd100, 16'h0, 16'h0, 2'b01, 32'd0, 1'b1);
        tick(3);
        mul_lat = 4;

        // Reset while waiting: no Ack, and no new grant until the multiplier is Idle.
        mul_hang = 1'b1;
        Sinal = 2'b00; OpA0 = 16'd9; OpB0 = 16'd9; Req = 2'b01;
        wait_st("st_pre_rst");
        tick(3);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_ack", 32'(Ack), 32'd0);
        chk("midrst_ocupado", 32'(Ocupado), 32'd0);
        chk("midrst_res", Resultado, 32'd0);
        tick(4);
        @(negedge Clk);
        chk("blocked_ocupado", 32'(Ocupado), 32'd0);
        tick();
        mul_hang = 1'b0;
        mul_kick = 1'b1;
        tick();
        mul_kick = 1'b0;
        wait_ack("after_idle", 2'b01, 32'd81, 1'b0);
        tick();
        Req = 2'b00;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
